// File: rtl/z_writeback_stage_pkg.sv
// Shared definitions for the Z writeback stage.
//   - ALU opcode constants (shared with the ALU).
//   - Writeback FSM state encoding (2-bit).
package z_writeback_stage_pkg;

  // ALU opcodes referenced by the datapath
  localparam logic [4:0] ALU_OP_DIV = 5'b00001;
  localparam logic [4:0] ALU_OP_ADD = 5'b01100;
  localparam logic [4:0] ALU_OP_MUL = 5'b01111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRIVE_LO = 2'd1,
    ST_DRIVE_HI = 2'd2,
    ST_FINISH   = 2'd3
  } wb_state_e;

endpackage

// File: rtl/z_grant_timer.sv
// Loadable up-counter used to bound how long the writeback stage waits for
// a bus grant.
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   clr_i       synchronous clear (highest priority)
//   load_i      synchronous load of load_val_i
//   load_val_i  value loaded when load_i is high
//   en_i        increment enable
//   limit_o     high when the count is LIMIT-1, i.e. the next miss reaches LIMIT
module z_grant_timer #(
  parameter int LIMIT = 16,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         limit_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag one cycle early so a miss in this cycle is the LIMIT-th miss.
  assign limit_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/z_writeback_stage.sv
// Z writeback stage: captures the 64-bit ALU result into ZHI:ZLO and
// transfers it over the shared 32-bit bus with a request/grant handshake.
// Wide ops (MUL, DIV) transfer LO then HI; all others transfer LO only.
// Ports:
//   clk, clear (async active-low reset)
//   opcode, zin, start          : result capture (start sampled in IDLE)
//   busy                        : not IDLE
//   bus_req, bus_grant, bus_out, bus_out_en : bus handshake
//   lo_we, hi_we, rd_we         : one-cycle register write enables
//   z_lo, z_hi                  : captured result halves
//   done, err                   : completion / grant-timeout pulses
module z_writeback_stage
  import z_writeback_stage_pkg::*;
#(
  parameter logic [4:0] OP_MUL     = ALU_OP_MUL,
  parameter logic [4:0] OP_DIV     = ALU_OP_DIV,
  parameter int         WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [4:0]  opcode,
  input  logic [63:0] zin,
  input  logic        start,
  output logic        busy,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [31:0] bus_out,
  output logic        bus_out_en,
  output logic        lo_we,
  output logic        hi_we,
  output logic        rd_we,
  output logic [31:0] z_lo,
  output logic [31:0] z_hi,
  output logic        done,
  output logic        err
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  wb_state_e   state_q, state_d;
  logic [31:0] z_lo_q, z_lo_d;
  logic [31:0] z_hi_q, z_hi_d;
  logic [4:0]  op_q, op_d;
  logic        err_q, err_d;

  logic        wide;
  logic        tmr_clr;
  logic        tmr_load;
  logic        tmr_en;
  logic        tmr_limit;

  // Width of the result is derived from the stored opcode; unknown opcodes are narrow.
  assign wide = (op_q == OP_MUL) || (op_q == OP_DIV);

  z_grant_timer #(
    .LIMIT (WAIT_LIMIT),
    .W     (CNT_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (clear),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i ('0),
    .en_i       (tmr_en),
    .limit_o    (tmr_limit)
  );

  // State and data registers
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      z_lo_q  <= '0;
      z_hi_q  <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_lo_q  <= z_lo_d;
      z_hi_q  <= z_hi_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    z_lo_d  = z_lo_q;
    z_hi_d  = z_hi_q;
    op_d    = op_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          z_lo_d  = zin[31:0];
          z_hi_d  = zin[63:32];
          op_d    = opcode;
          state_d = ST_DRIVE_LO;
        end
      end
      ST_DRIVE_LO: begin
        if (bus_grant) begin
          state_d = wide ? ST_DRIVE_HI : ST_FINISH;
        end else if (tmr_limit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_DRIVE_HI: begin
        // A timeout here leaves the already-written LO register as is.
        if (bus_grant) begin
          state_d = ST_FINISH;
        end else if (tmr_limit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and timer-control logic
  always_comb begin
    busy     = 1'b0;
    bus_req  = 1'b0;
    bus_out  = '0;
    lo_we    = 1'b0;
    hi_we    = 1'b0;
    rd_we    = 1'b0;
    done     = 1'b0;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmr_load = start;
      end
      ST_DRIVE_LO: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        bus_out = z_lo_q;
        lo_we   = bus_grant & wide;
        rd_we   = bus_grant & ~wide;
        tmr_clr = bus_grant | tmr_limit;
        tmr_en  = ~bus_grant;
      end
      ST_DRIVE_HI: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        bus_out = z_hi_q;
        hi_we   = bus_grant;
        tmr_clr = bus_grant | tmr_limit;
        tmr_en  = ~bus_grant;
      end
      ST_FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign bus_out_en = bus_req & bus_grant;
  assign err        = err_q;
  assign z_lo       = z_lo_q;
  assign z_hi       = z_hi_q;

endmodule

// File: tb/tb_z_writeback_stage.sv
// Bench for z_writeback_stage: directed and randomized operations, each
// checked cycle-by-cycle against an expected transfer timeline built from
// the operation's width and its per-word grant delays.
module tb_z_writeback_stage;
  import z_writeback_stage_pkg::*;

  localparam int WL = 4;

  logic        clk;
  logic        clear;
  logic [4:0]  opcode;
  logic [63:0] zin;
  logic        start;
  logic        busy;
  logic        bus_req;
  logic        bus_grant;
  logic [31:0] bus_out;
  logic        bus_out_en;
  logic        lo_we;
  logic        hi_we;
  logic        rd_we;
  logic [31:0] z_lo;
  logic [31:0] z_hi;
  logic        done;
  logic        err;

  int n_cmp;
  int n_bad;
  logic [63:0] model_z;

  z_writeback_stage #(
    .WAIT_LIMIT (WL)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .opcode     (opcode),
    .zin        (zin),
    .start      (start),
    .busy       (busy),
    .bus_req    (bus_req),
    .bus_grant  (bus_grant),
    .bus_out    (bus_out),
    .bus_out_en (bus_out_en),
    .lo_we      (lo_we),
    .hi_we      (hi_we),
    .rd_we      (rd_we),
    .z_lo       (z_lo),
    .z_hi       (z_hi),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [39:0] obs_ctl;
  assign obs_ctl = {busy, bus_req, bus_out_en, lo_we, hi_we, rd_we, done, err, bus_out};

  function automatic logic [39:0] mk(input logic bz, input logic rq, input logic en,
                                     input logic lo, input logic hi, input logic rd,
                                     input logic dn, input logic er, input logic [31:0] w);
    return {bz, rq, en, lo, hi, rd, dn, er, w};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs at the falling edge, check, advance.
  task automatic cyc(input logic g, input logic s, input logic [63:0] zs, input logic [4:0] os,
                     input logic [39:0] ectl, input string tag);
    bus_grant = g;
    start     = s;
    zin       = zs;
    opcode    = os;
    #1;
    chk({tag, "/ctl"}, 64'(obs_ctl), 64'(ectl));
    chk({tag, "/z"}, {z_hi, z_lo}, model_z);
    @(posedge clk);
    @(negedge clk);
  endtask

  // One operation. dlo/dhi: cycles of grant-low before grant rises for each
  // word; a delay of WL or more means the grant never arrives for that word.
  task automatic run_op(input logic [4:0] op, input logic [63:0] z, input int dlo,
                        input int dhi, input logic noisy, input string tag);
    logic        wide;
    logic [31:0] word;
    int          d;
    int          n;
    logic        js;
    wide = (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
    cyc(1'($urandom), 1'b1, z, op, '0, {tag, "/accept"});
    model_z = z;
    for (int w = 0; w < (wide ? 2 : 1); w++) begin
      d    = (w == 0) ? dlo : dhi;
      word = (w == 0) ? z[31:0] : z[63:32];
      n    = (d < WL) ? d : WL;
      for (int i = 0; i < n; i++) begin
        js = noisy ? 1'($urandom) : 1'b0;
        cyc(1'b0, js, 64'hDEAD, 5'($urandom), mk(1, 1, 0, 0, 0, 0, 0, 0, word), {tag, "/wait"});
      end
      if (d >= WL) begin
        cyc(1'($urandom), 1'b0, 64'h0, op, mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0), {tag, "/err"});
        return;
      end
      js = noisy ? 1'($urandom) : 1'b0;
      cyc(1'b1, js, 64'hDEAD, 5'($urandom),
          mk(1, 1, 1, wide && (w == 0), w == 1, !wide, 0, 0, word), {tag, "/xfer"});
    end
    js = noisy ? 1'($urandom) : 1'b0;
    cyc(1'($urandom), js, 64'hDEAD, 5'($urandom), mk(1, 0, 0, 0, 0, 0, 1, 0, 32'h0), {tag, "/done"});
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'($urandom), 1'b0, {$urandom, $urandom}, 5'($urandom), '0, "idle");
    end
  endtask

  initial begin
    logic [4:0] rop;
    n_cmp     = 0;
    n_bad     = 0;
    model_z   = '0;
    clear     = 1'b0;
    start     = 1'b0;
    bus_grant = 1'b0;
    zin       = '0;
    opcode    = '0;
    #1;
    chk("reset/ctl", 64'(obs_ctl), 64'h0);
    chk("reset/z", {z_hi, z_lo}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    idle_gap(2);

    // Directed cases
    run_op(ALU_OP_ADD, 64'h0000_0000_0000_0007, 0, 0, 1'b0, "add");
    run_op(ALU_OP_MUL, 64'h0000_0001_FFFF_FFFE, 0, 0, 1'b0, "mul");
    run_op(ALU_OP_DIV, 64'h1234_5678_9ABC_DEF0, WL - 1, 0, 1'b0, "div_delay");
    run_op(5'b01010, 64'hCAFE_0000_0000_00AA, 100, 0, 1'b0, "narrow_tmo");
    run_op(ALU_OP_MUL, 64'hAAAA_5555_1111_2222, 0, 100, 1'b0, "mul_hi_tmo");
    run_op(ALU_OP_MUL, 64'h0BAD_F00D_0000_0001, 0, 2, 1'b1, "busy_start");
    run_op(5'b11111, 64'h0000_0000_0000_0000, 1, 0, 1'b0, "unknown_op");
    idle_gap(1);

    // Randomized operations
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0:       rop = ALU_OP_MUL;
        1:       rop = ALU_OP_DIV;
        2:       rop = ALU_OP_ADD;
        default: rop = 5'($urandom);
      endcase
      run_op(rop, {$urandom, $urandom}, $urandom_range(0, WL + 1), $urandom_range(0, WL + 1),
             1'($urandom), "rand");
      idle_gap($urandom_range(0, 2));
    end

    // Reset in the middle of a wide op's HI transfer
    cyc(1'b0, 1'b1, 64'h7777_8888_9999_AAAA, ALU_OP_MUL, '0, "rst/accept");
    model_z = 64'h7777_8888_9999_AAAA;
    cyc(1'b1, 1'b0, 64'h0, ALU_OP_MUL, mk(1, 1, 1, 1, 0, 0, 0, 0, 32'h9999_AAAA), "rst/lo");
    bus_grant = 1'b0;
    #1;
    chk("rst/hi_drive", 64'(obs_ctl), 64'(mk(1, 1, 0, 0, 0, 0, 0, 0, 32'h7777_8888)));
    #2;
    clear = 1'b0;
    #1;
    model_z = '0;
    chk("rst/async_ctl", 64'(obs_ctl), 64'h0);
    chk("rst/async_z", {z_hi, z_lo}, 64'h0);
    bus_grant = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 64'h0, ALU_OP_MUL, '0, "rst/after");
    end
    run_op(ALU_OP_ADD, 64'h0000_0000_0000_0003, 0, 0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
